// File: rtl/sha256_msg_schedule_if.sv
// Handshake bundle between the SHA-256 message-schedule expander and its block source / word sink.
interface sha256_msg_schedule_if;
  logic         load_i;
  logic [511:0] block_i;
  logic         ready_o;
  logic         w_valid_o;
  logic         w_ready_i;
  logic [31:0]  w_o;
  logic [5:0]   w_idx_o;
  logic         done_o;

  modport master (
    output load_i, block_i, w_ready_i,
    input  ready_o, w_valid_o, w_o, w_idx_o, done_o
  );

  modport slave (
    input  load_i, block_i, w_ready_i,
    output ready_o, w_valid_o, w_o, w_idx_o, done_o
  );
endinterface

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message-schedule expander: loads one 512-bit block and streams W_0..W_63
// over a valid/ready handshake using a sliding 16-word window.
module sha256_msg_schedule #(
  parameter int unsigned NUM_WORDS = 64
) (
  input  logic                  CLK,
  input  logic                  RST,
  sha256_msg_schedule_if.slave  bus
);

  localparam logic [5:0] LastIdx = 6'(NUM_WORDS - 1);

  typedef enum logic {StIdle, StRun} state_e;

  state_e      state_q, state_d;
  logic [5:0]  t_q, t_d;
  logic        done_q, done_d;
  logic [31:0] win_q [16];
  logic [31:0] win_d [16];

  logic        xfer;
  logic [31:0] w_next;

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  assign xfer   = (state_q == StRun) && bus.w_ready_i;
  // Words past W_63 are still computed but only ever enter win[15], never the emitted slot.
  assign w_next = sigma1(win_q[14]) + win_q[9] + sigma0(win_q[1]) + win_q[0];

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    done_d  = 1'b0;
    win_d   = win_q;
    unique case (state_q)
      StIdle: begin
        if (bus.load_i) begin
          for (int i = 0; i < 16; i++) begin
            win_d[i] = bus.block_i[511 - 32*i -: 32];
          end
          t_d     = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (xfer) begin
          for (int i = 0; i < 15; i++) begin
            win_d[i] = win_q[i+1];
          end
          win_d[15] = w_next;
          t_d       = t_q + 6'd1;
          if (t_q == LastIdx) begin
            state_d = StIdle;
            done_d  = 1'b1;
            t_d     = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      t_q     <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      done_q  <= done_d;
      win_q   <= win_d;
    end
  end

  assign bus.ready_o   = (state_q == StIdle);
  assign bus.w_valid_o = (state_q == StRun);
  assign bus.w_o       = (state_q == StRun) ? win_q[0] : '0;
  assign bus.w_idx_o   = t_q;
  assign bus.done_o    = done_q;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Directed scoreboard bench for sha256_msg_schedule: expected words come from an
// independent schedule model and are queued at load time, then popped per transfer.
module tb_sha256_msg_schedule;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  sha256_msg_schedule_if bus ();

  sha256_msg_schedule #(.NUM_WORDS(64)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] exp_w [$];
  logic [5:0]  exp_i [$];

  logic [511:0] abc_blk;
  logic [511:0] alt_blk;
  logic [511:0] zero_blk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] model_w(input logic [511:0] blk, input int t);
    logic [31:0] w [64];
    for (int j = 0; j < 16; j++) w[j] = blk[511 - 32*j -: 32];
    for (int j = 16; j < 64; j++) begin
      w[j] = (rotr(w[j-2], 17) ^ rotr(w[j-2], 19) ^ (w[j-2] >> 10)) + w[j-7]
           + (rotr(w[j-15], 7) ^ rotr(w[j-15], 18) ^ (w[j-15] >> 3)) + w[j-16];
    end
    return w[t];
  endfunction

  // Called at a negedge while ready_o should be high; returns 1 ns after the load edge.
  task automatic load_block(input logic [511:0] blk);
    check("ready_before_load", 64'(bus.ready_o), 64'd1);
    bus.load_i  = 1'b1;
    bus.block_i = blk;
    for (int t = 0; t < 64; t++) begin
      exp_w.push_back(model_w(blk, t));
      exp_i.push_back(6'(t));
    end
    @(posedge CLK);
    #1;
    bus.load_i = 1'b0;
  endtask

  // Consumes queued words; returns at the negedge of the done cycle (or after a reset abort).
  task automatic drain(input bit bp, input int inj_at, input int rst_at);
    int guard = 0;
    int xfers = 0;
    while (exp_w.size() > 0) begin
      @(negedge CLK);
      guard++;
      if (guard > 5000) begin
        check("drain_timeout", 64'(exp_w.size()), 64'd0);
        exp_w.delete();
        exp_i.delete();
        return;
      end
      if (int'(exp_i[0]) == rst_at) begin
        bus.load_i = 1'b0;
        RST = 1'b1;
        #1;
        check("rst_mid_ready", 64'(bus.ready_o), 64'd1);
        check("rst_mid_valid", 64'(bus.w_valid_o), 64'd0);
        check("rst_mid_w", 64'(bus.w_o), 64'd0);
        check("rst_mid_idx", 64'(bus.w_idx_o), 64'd0);
        check("rst_mid_done", 64'(bus.done_o), 64'd0);
        @(negedge CLK);
        check("rst_hold_done", 64'(bus.done_o), 64'd0);
        RST = 1'b0;
        exp_w.delete();
        exp_i.delete();
        return;
      end
      bus.load_i  = (int'(exp_i[0]) == inj_at);
      bus.block_i = alt_blk;
      bus.w_ready_i = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      check("run_valid", 64'(bus.w_valid_o), 64'd1);
      check("run_ready", 64'(bus.ready_o), 64'd0);
      check("run_done", 64'(bus.done_o), 64'd0);
      check("run_w", 64'(bus.w_o), 64'(exp_w[0]));
      check("run_idx", 64'(bus.w_idx_o), 64'(exp_i[0]));
      if (bus.w_ready_i) begin
        void'(exp_w.pop_front());
        void'(exp_i.pop_front());
        xfers++;
      end
    end
    bus.load_i = 1'b0;
    @(negedge CLK);
    check("xfer_count", 64'(xfers), 64'd64);
    check("done_pulse", 64'(bus.done_o), 64'd1);
    check("done_valid", 64'(bus.w_valid_o), 64'd0);
    check("done_ready", 64'(bus.ready_o), 64'd1);
    check("done_idx", 64'(bus.w_idx_o), 64'd0);
  endtask

  initial begin
    abc_blk  = {32'h61626380, 448'h0, 32'h00000018};
    alt_blk  = {16{32'hDEADBEEF}};
    zero_blk = '0;
    bus.load_i    = 1'b0;
    bus.block_i   = '0;
    bus.w_ready_i = 1'b0;

    // Asynchronous reset asserted mid-cycle, checked before any clock edge.
    @(negedge CLK);
    RST = 1'b1;
    #1;
    check("rst_ready", 64'(bus.ready_o), 64'd1);
    check("rst_valid", 64'(bus.w_valid_o), 64'd0);
    check("rst_done", 64'(bus.done_o), 64'd0);
    check("rst_w", 64'(bus.w_o), 64'd0);
    check("rst_idx", 64'(bus.w_idx_o), 64'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      check("idle_valid", 64'(bus.w_valid_o), 64'd0);
      check("idle_ready", 64'(bus.ready_o), 64'd1);
      check("idle_done", 64'(bus.done_o), 64'd0);
    end

    // Known-answer values for the "abc" schedule.
    check("kat_w16", 64'(model_w(abc_blk, 16)), 64'h61626380);
    check("kat_w17", 64'(model_w(abc_blk, 17)), 64'h000F0000);
    check("kat_w18", 64'(model_w(abc_blk, 18)), 64'h7DA86405);
    check("kat_w63", 64'(model_w(abc_blk, 63)), 64'h12B1EDEB);

    // Full throughput.
    @(negedge CLK);
    load_block(abc_blk);
    drain(1'b0, -1, -1);
    @(negedge CLK);
    check("done_one_cycle", 64'(bus.done_o), 64'd0);

    // Random backpressure.
    @(negedge CLK);
    load_block(abc_blk);
    drain(1'b1, -1, -1);
    @(negedge CLK);

    // Load pulse during RUN is ignored.
    @(negedge CLK);
    load_block(abc_blk);
    drain(1'b0, 10, -1);
    @(negedge CLK);

    // Back-to-back: next block loaded in the done cycle.
    @(negedge CLK);
    load_block(abc_blk);
    drain(1'b0, -1, -1);
    load_block(zero_blk);
    drain(1'b1, -1, -1);
    @(negedge CLK);
    check("b2b_done_drop", 64'(bus.done_o), 64'd0);

    // Reset at t=30, then a clean reload.
    @(negedge CLK);
    load_block(abc_blk);
    drain(1'b0, -1, 30);
    @(negedge CLK);
    check("post_rst_valid", 64'(bus.w_valid_o), 64'd0);
    check("post_rst_ready", 64'(bus.ready_o), 64'd1);
    check("post_rst_done", 64'(bus.done_o), 64'd0);
    load_block(abc_blk);
    drain(1'b1, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
